dense_layer_mac_engine: RTL and testbench

Parametrised fully-connected layer engine for the generator/discriminator datapath. It is the next generation of the fixed 256x256 sequential-MAC layer blocks.
- Computes out[n] = act(sat(bias[n] + sum_i in[i]*W[n][i])) in signed Q(DATA_W-FRAC).FRAC.
- Uses LANES parallel MAC lanes over OUT_DIM/LANES neuron groups.
- Weights and bias are fetched through external 1-cycle-latency ROM ports.
- Keeps the flat-bus, start/done interface so it drops into the existing layer chain.

---
 rtl/gan_layer_pkg.sv | 82 ++++++++
 rtl/dense_mac_lane.sv | 67 ++++++
 rtl/dense_layer_mac_engine.sv | 189 ++++++++++++++++++
 tb/tb_dense_layer_mac_engine.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gan_layer_pkg.sv
// Shared definitions for the dense layer MAC engine.
// - act_mode_e : activation encodings carried on act_mode
// - state_e    : sequencing states of the layer FSM
// - sat_check / saturate / activate : width-generic helpers working on a
//   CALC_W signed container; callers pass DATA_W / FRAC and truncate.
package gan_layer_pkg;

  localparam int LEAKY_SHIFT = 3;
  localparam int CALC_W      = 64;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2,
    ACT_HTANH = 2'd3
  } act_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BIAS  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // True when val lies outside the signed data_w-bit range.
  function automatic logic sat_check(input logic signed [CALC_W-1:0] val,
                                     input int data_w);
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    return (val > hi) || (val < lo);
  endfunction

  // Clamp val into the signed data_w-bit range.
  function automatic logic signed [CALC_W-1:0] saturate(input logic signed [CALC_W-1:0] val,
                                                        input int data_w);
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    logic signed [CALC_W-1:0] res;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (val > hi) begin
      res = hi;
    end else if (val < lo) begin
      res = lo;
    end else begin
      res = val;
    end
    return res;
  endfunction

  // Apply the selected activation; hardtanh clamps to +/-1.0 in Q.frac.
  function automatic logic signed [CALC_W-1:0] activate(input logic signed [CALC_W-1:0] val,
                                                        input act_mode_e mode,
                                                        input int frac);
    logic signed [CALC_W-1:0] one;
    logic signed [CALC_W-1:0] res;
    one = 64'sd1 <<< frac;
    case (mode)
      ACT_NONE: res = val;
      ACT_RELU: begin
        if (val < 64'sd0) res = 64'sd0;
        else              res = val;
      end
      ACT_LEAKY: begin
        if (val < 64'sd0) res = val >>> LEAKY_SHIFT;
        else              res = val;
      end
      ACT_HTANH: begin
        if (val > one)       res = one;
        else if (val < -one) res = -one;
        else                 res = val;
      end
      default: res = val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dense_mac_lane.sv
// One MAC lane: accumulates bias<<<FRAC plus weight*activation products for a
// single neuron and presents the finalised (shift, saturate, activate) value.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   load_bias   : load accumulator with sign-extended bias<<<FRAC
//   accumulate  : add weight*act_in into the accumulator
//   finalise    : qualifies the saturation flag for the write cycle
//   act_mode    : activation applied after saturation
//   bias, weight, act_in : signed DATA_W operands
//   result      : activated, saturated DATA_W value of the current accumulator
//   sat         : finalise & (shifted accumulator out of DATA_W range)
module dense_mac_lane
  import gan_layer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC   = 8,
  parameter int ACC_W  = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_bias,
  input  logic                     accumulate,
  input  logic                     finalise,
  input  act_mode_e                act_mode,
  input  logic signed [DATA_W-1:0] bias,
  input  logic signed [DATA_W-1:0] weight,
  input  logic signed [DATA_W-1:0] act_in,
  output logic        [DATA_W-1:0] result,
  output logic                     sat
);

  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]    bias_ext_s;
  logic signed [ACC_W-1:0]    acc_r;
  logic signed [CALC_W-1:0]   shifted_s;
  logic signed [CALC_W-1:0]   sat_val_s;
  logic signed [CALC_W-1:0]   act_val_s;
  logic                       sat_s;

  assign prod_s     = (2*DATA_W)'(weight) * (2*DATA_W)'(act_in);
  assign bias_ext_s = ACC_W'(bias) <<< FRAC;

  // Accumulator: bias load, product accumulation, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {ACC_W{1'b0}};
    end else if (load_bias) begin
      acc_r <= bias_ext_s;
    end else if (accumulate) begin
      acc_r <= acc_r + ACC_W'(prod_s);
    end else begin
      acc_r <= acc_r;
    end
  end

  // Finalise path: arithmetic shift (floor), saturate, then activation.
  always_comb begin
    shifted_s = CALC_W'(acc_r) >>> FRAC;
    sat_s     = sat_check(shifted_s, DATA_W);
    sat_val_s = saturate(shifted_s, DATA_W);
    act_val_s = activate(sat_val_s, act_mode, FRAC);
  end

  assign result = DATA_W'(act_val_s);
  assign sat    = finalise & sat_s;

endmodule

// File: rtl/dense_layer_mac_engine.sv
// Fully-connected layer engine: out[n] = act(sat(bias[n] + sum in[i]*W[n][i])).
// LANES neurons are computed concurrently per group; weights and biases come
// from external ROMs with one cycle of read latency.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   start, act_mode  : run request (ignored while busy) and activation select
//   flat_input_flat  : input vector, element i at [(i+1)*DATA_W-1 -: DATA_W]
//   w_addr / w_data  : weight ROM, address group*IN_DIM+i, lane l slice = W[group*LANES+l][i]
//   b_addr / b_data  : bias ROM, address group, lane l slice = bias[group*LANES+l]
//   flat_output_flat : result vector, same packing as the input
//   busy, done       : run in progress / one-cycle completion pulse
//   overflow         : sticky saturation flag for the current run
module dense_layer_mac_engine
  import gan_layer_pkg::*;
#(
  parameter int IN_DIM  = 256,
  parameter int OUT_DIM = 256,
  parameter int LANES   = 4,
  parameter int DATA_W  = 16,
  parameter int FRAC    = 8,
  parameter int ACC_W   = 40,
  localparam int GROUPS = OUT_DIM / LANES,
  localparam int WA_W   = (GROUPS * IN_DIM > 1) ? $clog2(GROUPS * IN_DIM) : 1,
  localparam int BA_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                act_mode,
  input  logic [DATA_W*IN_DIM-1:0]  flat_input_flat,
  output logic [WA_W-1:0]           w_addr,
  input  logic [LANES*DATA_W-1:0]   w_data,
  output logic [BA_W-1:0]           b_addr,
  input  logic [LANES*DATA_W-1:0]   b_data,
  output logic [DATA_W*OUT_DIM-1:0] flat_output_flat,
  output logic                      busy,
  output logic                      done,
  output logic                      overflow
);

  localparam int IDX_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;

  state_e                    state_r;
  state_e                    state_nxt_s;
  logic                      start_acc_s;
  logic                      last_mac_s;
  logic                      last_grp_s;
  logic                      write_s;

  logic [BA_W-1:0]           group_r;
  logic [IDX_W-1:0]          idx_r;
  logic [IDX_W-1:0]          x_sel_r;
  logic [WA_W-1:0]           w_addr_r;
  logic [DATA_W*IN_DIM-1:0]  in_r;
  act_mode_e                 mode_r;
  logic                      load_bias_r;
  logic                      accum_r;
  logic [DATA_W*OUT_DIM-1:0] out_r;
  logic                      busy_r;
  logic                      done_r;
  logic                      ovf_r;

  logic [DATA_W-1:0]         act_in_s;
  logic [DATA_W-1:0]         lane_res_s [LANES];
  logic [LANES-1:0]          lane_sat_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and start acceptance.
  always_comb begin
    state_nxt_s = state_r;
    start_acc_s = 1'b0;
    last_mac_s  = (idx_r == IDX_W'(IN_DIM - 1));
    last_grp_s  = (group_r == BA_W'(GROUPS - 1));
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_BIAS;
          start_acc_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BIAS: state_nxt_s = ST_MAC;
      ST_MAC: begin
        if (last_mac_s) state_nxt_s = ST_DRAIN;
        else            state_nxt_s = ST_MAC;
      end
      ST_DRAIN: state_nxt_s = ST_WRITE;
      ST_WRITE: begin
        if (last_grp_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_BIAS;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign write_s  = (state_r == ST_WRITE);
  // x_sel_r trails idx_r by one cycle so it lines up with the ROM latency.
  assign act_in_s = in_r[int'(x_sel_r)*DATA_W +: DATA_W];

  // Datapath: input latch, address counters, lane controls, output file.
  always_ff @(posedge clk) begin
    if (rst) begin
      group_r     <= {BA_W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      x_sel_r     <= {IDX_W{1'b0}};
      w_addr_r    <= {WA_W{1'b0}};
      in_r        <= {(DATA_W*IN_DIM){1'b0}};
      mode_r      <= ACT_NONE;
      load_bias_r <= 1'b0;
      accum_r     <= 1'b0;
      out_r       <= {(DATA_W*OUT_DIM){1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      // Bias data arrives the cycle after BIAS; products the cycle after each MAC address.
      load_bias_r <= (state_r == ST_BIAS);
      accum_r     <= (state_r == ST_MAC);
      x_sel_r     <= idx_r;
      busy_r      <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE);
      done_r      <= (state_nxt_s == ST_DONE);
      if (start_acc_s) begin
        in_r     <= flat_input_flat;
        mode_r   <= act_mode_e'(act_mode);
        ovf_r    <= 1'b0;
        group_r  <= {BA_W{1'b0}};
        idx_r    <= {IDX_W{1'b0}};
        w_addr_r <= {WA_W{1'b0}};
      end else begin
        case (state_r)
          ST_MAC: begin
            idx_r <= last_mac_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1'b1);
            // Running address naturally steps into the next group's base.
            if (last_mac_s && last_grp_s) w_addr_r <= {WA_W{1'b0}};
            else                          w_addr_r <= w_addr_r + WA_W'(1'b1);
          end
          ST_WRITE: begin
            for (int l = 0; l < LANES; l++) begin
              out_r[(int'(group_r)*LANES + l)*DATA_W +: DATA_W] <= lane_res_s[l];
            end
            ovf_r   <= ovf_r | (|lane_sat_s);
            group_r <= last_grp_s ? {BA_W{1'b0}} : group_r + BA_W'(1'b1);
          end
          default: begin
            idx_r <= idx_r;
          end
        endcase
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    dense_mac_lane #(
      .DATA_W (DATA_W),
      .FRAC   (FRAC),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .load_bias  (load_bias_r),
      .accumulate (accum_r),
      .finalise   (write_s),
      .act_mode   (mode_r),
      .bias       (b_data[l*DATA_W +: DATA_W]),
      .weight     (w_data[l*DATA_W +: DATA_W]),
      .act_in     (act_in_s),
      .result     (lane_res_s[l]),
      .sat        (lane_sat_s[l])
    );
  end

  assign w_addr           = w_addr_r;
  assign b_addr           = group_r;
  assign flat_output_flat = out_r;
  assign busy             = busy_r;
  assign done             = done_r;
  assign overflow         = ovf_r;

endmodule

// File: tb/tb_dense_layer_mac_engine.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, per-DUT
// monitors pop and compare on each done pulse. Latency is counted from the
// cycle start is presented to the cycle done is high.
module tb_dense_layer_mac_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- small instance: IN=4, OUT=4, LANES=2 ----------------
  logic        s_start;
  logic [1:0]  s_mode;
  logic [63:0] s_in;
  logic [2:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [0:0]  s_baddr;
  logic [31:0] s_bdata;
  logic [63:0] s_out;
  logic        s_busy, s_done, s_ovf;

  dense_layer_mac_engine #(.IN_DIM(4), .OUT_DIM(4), .LANES(2)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .act_mode(s_mode),
    .flat_input_flat(s_in), .w_addr(s_waddr), .w_data(s_wdata),
    .b_addr(s_baddr), .b_data(s_bdata), .flat_output_flat(s_out),
    .busy(s_busy), .done(s_done), .overflow(s_ovf)
  );

  logic [15:0] w_mem [0:3][0:3];
  logic [15:0] bias_mem [0:3];

  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      s_wdata[l*16 +: 16] <= w_mem[(int'(s_waddr) / 4) * 2 + l][int'(s_waddr) % 4];
      s_bdata[l*16 +: 16] <= bias_mem[int'(s_baddr) * 2 + l];
    end
  end

  // ---------------- default instance: 256x256, LANES=4 ----------------
  logic          b_start;
  logic [1:0]    b_mode;
  logic [4095:0] b_in;
  logic [13:0]   b_waddr;
  logic [63:0]   b_wdata;
  logic [5:0]    b_baddr;
  logic [63:0]   b_bdata;
  logic [4095:0] b_out;
  logic          b_busy, b_done, b_ovf;

  dense_layer_mac_engine u_big (
    .clk(clk), .rst(rst), .start(b_start), .act_mode(b_mode),
    .flat_input_flat(b_in), .w_addr(b_waddr), .w_data(b_wdata),
    .b_addr(b_baddr), .b_data(b_bdata), .flat_output_flat(b_out),
    .busy(b_busy), .done(b_done), .overflow(b_ovf)
  );

  always @(posedge clk) begin
    b_wdata <= {4{2'b01, b_waddr}};
    for (int l = 0; l < 4; l++) begin
      b_bdata[l*16 +: 16] <= 16'((int'(b_baddr) * 4 + l) * 16);
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [63:0] out;
    logic        ovf;
    int          lat;
    int          t0;
  } s_exp_t;

  typedef struct {
    logic [4095:0] out;
    logic          ovf;
    int            lat;
    int            t0;
  } b_exp_t;

  s_exp_t s_q[$];
  b_exp_t b_q[$];
  s_exp_t s_mon_e;
  b_exp_t b_mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (s_done === 1'b1) begin
      if (s_q.size() == 0) begin
        check("s_unexpected_done", 64'd1, 64'd0);
      end else begin
        s_mon_e = s_q.pop_front();
        check("s_out", s_out, s_mon_e.out);
        check("s_overflow", {63'd0, s_ovf}, {63'd0, s_mon_e.ovf});
        check("s_latency", 64'(cyc - s_mon_e.t0), 64'(s_mon_e.lat));
        check("s_busy_at_done", {63'd0, s_busy}, 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (b_done === 1'b1) begin
      if (b_q.size() == 0) begin
        check("b_unexpected_done", 64'd1, 64'd0);
      end else begin
        int bad;
        int first;
        bad = 0;
        first = -1;
        b_mon_e = b_q.pop_front();
        for (int n = 0; n < 256; n++) begin
          if (b_out[n*16 +: 16] !== b_mon_e.out[n*16 +: 16]) begin
            bad++;
            if (first < 0) first = n;
          end
        end
        if (first >= 0)
          $display("first bad neuron %0d: got %0h expected %0h", first,
                   b_out[first*16 +: 16], b_mon_e.out[first*16 +: 16]);
        check("b_out_bad_neurons", 64'(bad), 64'd0);
        check("b_overflow", {63'd0, b_ovf}, {63'd0, b_mon_e.ovf});
        check("b_latency", 64'(cyc - b_mon_e.t0), 64'(b_mon_e.lat));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic fill_w(input logic [15:0] v);
    for (int n = 0; n < 4; n++)
      for (int i = 0; i < 4; i++)
        w_mem[n][i] = v;
  endtask

  task automatic set_bias(input logic [15:0] b0, input logic [15:0] b1,
                          input logic [15:0] b2, input logic [15:0] b3);
    bias_mem[0] = b0; bias_mem[1] = b1; bias_mem[2] = b2; bias_mem[3] = b3;
  endtask

  task automatic s_go(input logic [63:0] v, input logic [1:0] m, input bit push,
                      input logic [63:0] eo, input logic eovf);
    s_exp_t e;
    @(negedge clk);
    s_in = v;
    s_mode = m;
    s_start = 1'b1;
    if (push) begin
      e.out = eo; e.ovf = eovf; e.lat = 15; e.t0 = cyc;
      s_q.push_back(e);
    end
    @(negedge clk);
    s_start = 1'b0;
  endtask

  task automatic s_wait_done(input bit poke_in_done);
    int n;
    n = 0;
    while (s_done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s_done_seen", {63'd0, s_done}, 64'd1);
    if (poke_in_done) s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    b_exp_t be;
    logic [4095:0] bexp;
    rst = 1'b1;
    s_start = 1'b0; s_mode = 2'd0; s_in = 64'd0;
    b_start = 1'b0; b_mode = 2'd0; b_in = 4096'd0;
    fill_w(16'h0000);
    set_bias(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    repeat (3) @(negedge clk);

    check("rst_busy", {63'd0, s_busy}, 64'd0);
    check("rst_done", {63'd0, s_done}, 64'd0);
    check("rst_overflow", {63'd0, s_ovf}, 64'd0);
    check("rst_out", s_out, 64'd0);
    check("rst_w_addr", {61'd0, s_waddr}, 64'd0);
    check("rst_b_addr", {63'd0, s_baddr}, 64'd0);
    check("rst_big_out_low", b_out[63:0], 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Default geometry: inputs zero, bias[n]=n*0x10 -> out[n]=n*0x10.
    for (int n = 0; n < 256; n++) bexp[n*16 +: 16] = 16'(n * 16);
    b_in = 4096'd0;
    b_mode = 2'd0;
    b_start = 1'b1;
    be.out = bexp; be.ovf = 1'b0; be.lat = 64 * 259 + 1; be.t0 = cyc;
    b_q.push_back(be);
    @(negedge clk);
    b_start = 1'b0;
    begin
      int n;
      n = 0;
      while (b_done !== 1'b1 && n < 17000) begin
        @(negedge clk);
        n++;
      end
      check("b_done_seen", {63'd0, b_done}, 64'd1);
      @(negedge clk);
    end

    // 1.0 inputs, 0.5 weights, zero bias -> 2.0
    fill_w(16'h0080);
    set_bias(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    s_go({4{16'h0100}}, 2'd0, 1'b1, {4{16'h0200}}, 1'b0);
    s_wait_done(1'b0);

    // positive saturation
    fill_w(16'h7FFF);
    s_go({4{16'h7FFF}}, 2'd0, 1'b1, {4{16'h7FFF}}, 1'b1);
    s_wait_done(1'b0);

    // negative saturation
    fill_w(16'h8001);
    s_go({4{16'h7FFF}}, 2'd0, 1'b1, {4{16'h8000}}, 1'b1);
    s_wait_done(1'b0);

    // Diagonal weights: per-element ordering, bias add, floor on negative.
    fill_w(16'h0000);
    w_mem[0][0] = 16'h0100; w_mem[1][1] = 16'h0100;
    w_mem[2][2] = 16'h0100; w_mem[3][3] = 16'h0080;
    set_bias(16'h0000, 16'h0010, 16'h0020, 16'h0000);
    s_go({16'hFFFF, 16'hFF00, 16'h0200, 16'h0100}, 2'd0, 1'b1,
         {16'hFFFF, 16'hFF20, 16'h0210, 16'h0100}, 1'b0);
    s_wait_done(1'b0);

    // Activations: pre-activation -2.0 on neurons 0,1 and +3.0 on 2,3.
    fill_w(16'h0000);
    set_bias(16'hFE00, 16'hFE00, 16'h0300, 16'h0300);
    s_go(64'd0, 2'd0, 1'b1, {16'h0300, 16'h0300, 16'hFE00, 16'hFE00}, 1'b0);
    s_wait_done(1'b0);
    s_go(64'd0, 2'd1, 1'b1, {16'h0300, 16'h0300, 16'h0000, 16'h0000}, 1'b0);
    s_wait_done(1'b0);
    s_go(64'd0, 2'd2, 1'b1, {16'h0300, 16'h0300, 16'hFFC0, 16'hFFC0}, 1'b0);
    s_wait_done(1'b0);
    s_go(64'd0, 2'd3, 1'b1, {16'h0100, 16'h0100, 16'hFF00, 16'hFF00}, 1'b0);
    s_wait_done(1'b0);

    // start re-pulsed mid-run and again during the DONE cycle: both ignored.
    fill_w(16'h0080);
    set_bias(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    s_go({4{16'h0100}}, 2'd0, 1'b1, {4{16'h0200}}, 1'b0);
    repeat (4) @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    s_wait_done(1'b1);
    repeat (3) @(negedge clk);
    check("busy_after_done_start", {63'd0, s_busy}, 64'd0);

    // Inputs and mode changed right after accept: latched values win.
    s_go({4{16'h0100}}, 2'd0, 1'b1, {4{16'h0200}}, 1'b0);
    s_in = 64'd0;
    s_mode = 2'd3;
    s_wait_done(1'b0);

    // Reset ten cycles into a saturating run, then a clean run.
    fill_w(16'h7FFF);
    s_go({4{16'h7FFF}}, 2'd0, 1'b0, 64'd0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {63'd0, s_busy}, 64'd0);
    check("midrst_done", {63'd0, s_done}, 64'd0);
    check("midrst_out", s_out, 64'd0);
    check("midrst_overflow", {63'd0, s_ovf}, 64'd0);
    rst = 1'b0;
    fill_w(16'h0080);
    s_go({4{16'h0100}}, 2'd0, 1'b1, {4{16'h0200}}, 1'b0);
    s_wait_done(1'b0);

    repeat (3) @(negedge clk);
    check("s_queue_drained", 64'(s_q.size()), 64'd0);
    check("b_queue_drained", 64'(b_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
